// File: rtl/cam_gen_pkg.sv
// Shared encodings for the camera pattern generator: pattern modes, FSM states
// and the RGB444 two-byte split used on CAM_px_data.
package cam_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_STRIPE = 2'd1,
        MODE_BAND   = 2'd2,
        MODE_CHECK  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBLANK,
        ACTIVE,
        HBLANK
    } state_t;

    // First byte carries R in the low nibble, second byte carries {G,B}.
    function automatic logic [7:0] rgb444_byte(input logic [11:0] color, input logic second);
        return second ? color[7:0] : {4'h0, color[11:8]};
    endfunction

endpackage

// File: rtl/cam_pattern_color.sv
// Pixel colour selection from stripe/band sub-counters with parity flops; colour is
// combinational from registered state, counters move only on the top-level strobes.
module cam_pattern_color
    import cam_gen_pkg::*;
#(
    parameter int STRIPE_W = 2,
    parameter int BAND_H   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_x_adv,
    input  logic        i_x_clr,
    input  logic        i_y_adv,
    input  logic        i_y_clr,
    input  mode_t       i_mode,
    input  logic [11:0] i_color_a,
    input  logic [11:0] i_color_b,
    output logic [11:0] o_color
);

    localparam int SW = $clog2(STRIPE_W) + 1;
    localparam int BW = $clog2(BAND_H) + 1;

    logic [SW-1:0] r_xs;
    logic          r_xpar;
    logic [BW-1:0] r_ys;
    logic          r_ypar;
    logic          w_sel_b;

    // Parity of x/STRIPE_W and y/BAND_H tracked incrementally instead of dividing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xs   <= '0;
            r_xpar <= 1'b0;
            r_ys   <= '0;
            r_ypar <= 1'b0;
        end else begin
            if (i_x_clr) begin
                r_xs   <= '0;
                r_xpar <= 1'b0;
            end else if (i_x_adv) begin
                if (r_xs == SW'(STRIPE_W - 1)) begin
                    r_xs   <= '0;
                    r_xpar <= ~r_xpar;
                end else begin
                    r_xs <= r_xs + 1'b1;
                end
            end
            if (i_y_clr) begin
                r_ys   <= '0;
                r_ypar <= 1'b0;
            end else if (i_y_adv) begin
                if (r_ys == BW'(BAND_H - 1)) begin
                    r_ys   <= '0;
                    r_ypar <= ~r_ypar;
                end else begin
                    r_ys <= r_ys + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_b = 1'b0;
        case (i_mode)
            MODE_SOLID:  w_sel_b = 1'b0;
            MODE_STRIPE: w_sel_b = r_xpar;
            MODE_BAND:   w_sel_b = r_ypar;
            MODE_CHECK:  w_sel_b = r_xpar ^ r_ypar;
            default:     w_sel_b = 1'b0;
        endcase
    end

    assign o_color = w_sel_b ? i_color_b : i_color_a;

endmodule

// File: rtl/cam_pattern_gen.sv
// OV7670-style RGB444 camera emulator; outputs change only on pclk fall ticks, en->vsync <= 2 clk.
// Free-running source with no backpressure: the capture side must keep up with pclk.
module cam_pattern_gen
    import cam_gen_pkg::*;
#(
    parameter int TAM_LINE       = 160,
    parameter int TAM_ROW        = 120,
    parameter int BLACK_TAM_LINE = 4,
    parameter int BLACK_TAM_ROW  = 4,
    parameter int VSYNC_ROWS     = 2,
    parameter int STRIPE_W       = 2,
    parameter int BAND_H         = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [11:0] color_a,
    input  logic [11:0] color_b,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int LT      = 2 * TAM_LINE + BLACK_TAM_LINE;
    localparam int VS_T    = VSYNC_ROWS * LT;
    localparam int VB_T    = (BLACK_TAM_ROW - VSYNC_ROWS) * LT;
    localparam int VB_LAST = (VB_T > 0) ? VB_T - 1 : 0;
    localparam int CW      = $clog2(BLACK_TAM_ROW * LT) + 1;
    localparam int YW      = $clog2(TAM_ROW) + 1;

    logic          r_pclk;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [YW-1:0] r_row, w_row_nxt;
    mode_t         r_mode;
    logic [11:0]   r_color_a, r_color_b;
    logic          r_frame_done;
    logic [7:0]    r_frame_cnt;
    logic          w_fall, w_load, w_frame_end;
    logic          w_x_adv, w_x_clr, w_y_adv, w_y_clr;
    logic [11:0]   w_color;

    assign w_fall = r_pclk;

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_row_nxt   = r_row;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        w_x_adv     = 1'b0;
        w_x_clr     = 1'b0;
        w_y_adv     = 1'b0;
        w_y_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (en) begin
                    w_next  = VSYNC;
                    w_load  = 1'b1;
                    w_y_clr = 1'b1;
                end
            end
            VSYNC: begin
                if (r_cnt == CW'(VS_T - 1)) begin
                    w_cnt_nxt = '0;
                    w_row_nxt = '0;
                    w_next    = (VB_T == 0) ? ACTIVE : VBLANK;
                end
            end
            VBLANK: begin
                if (r_cnt == CW'(VB_LAST)) begin
                    w_cnt_nxt = '0;
                    w_row_nxt = '0;
                    w_next    = ACTIVE;
                end
            end
            ACTIVE: begin
                w_x_adv = r_cnt[0];
                if (r_cnt == CW'(2 * TAM_LINE - 1)) begin
                    w_cnt_nxt = '0;
                    w_x_clr   = 1'b1;
                    w_next    = HBLANK;
                end
            end
            HBLANK: begin
                if (r_cnt == CW'(BLACK_TAM_LINE - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_row < YW'(TAM_ROW - 1)) begin
                        w_row_nxt = r_row + 1'b1;
                        w_y_adv   = 1'b1;
                        w_next    = ACTIVE;
                    end else begin
                        w_frame_end = 1'b1;
                        w_y_clr     = 1'b1;
                        w_load      = en;
                        w_next      = en ? VSYNC : IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_next    = IDLE;
            end
        endcase
    end

    // Shadows only reload at frame start so a frame never mixes patterns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pclk       <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_mode       <= MODE_SOLID;
            r_color_a    <= '0;
            r_color_b    <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pclk       <= ~r_pclk;
            r_frame_done <= w_fall & w_frame_end;
            if (w_fall) begin
                r_state <= w_next;
                r_cnt   <= w_cnt_nxt;
                r_row   <= w_row_nxt;
                if (w_load) begin
                    r_mode    <= mode_t'(mode);
                    r_color_a <= color_a;
                    r_color_b <= color_b;
                end
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    cam_pattern_color #(
        .STRIPE_W (STRIPE_W),
        .BAND_H   (BAND_H)
    ) u_color (
        .clk       (clk),
        .rst       (rst),
        .i_x_adv   (w_fall & w_x_adv),
        .i_x_clr   (w_fall & w_x_clr),
        .i_y_adv   (w_fall & w_y_adv),
        .i_y_clr   (w_fall & w_y_clr),
        .i_mode    (r_mode),
        .i_color_a (r_color_a),
        .i_color_b (r_color_b),
        .o_color   (w_color)
    );

    assign CAM_pclk    = r_pclk;
    assign CAM_vsync   = (r_state == VSYNC);
    assign CAM_href    = (r_state == ACTIVE);
    assign CAM_px_data = CAM_href ? rgb444_byte(w_color, r_cnt[0]) : 8'h00;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed bench for cam_pattern_gen with full-width lines and a shortened frame height.
module tb_cam_pattern_gen;

    localparam int TL      = 160;
    localparam int TR      = 12;
    localparam int BTL     = 4;
    localparam int BTR     = 4;
    localparam int VSR     = 2;
    localparam int SW      = 2;
    localparam int BH      = 3;
    localparam int FRAME_T = 5184;   // (4 + 12) rows * 324 pclk

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [11:0] color_a;
    logic [11:0] color_b;
    logic        CAM_pclk;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_stripe [0:7] = '{8'h00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hF0};
    logic [7:0] exp_chk0   [0:9] = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hF0, 8'h0F, 8'h0F};
    logic [7:0] exp_chk3   [0:9] = '{8'h00, 8'hF0, 8'h00, 8'hF0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'hF0};

    always #5 clk = ~clk;

    cam_pattern_gen #(
        .TAM_LINE       (TL),
        .TAM_ROW        (TR),
        .BLACK_TAM_LINE (BTL),
        .BLACK_TAM_ROW  (BTR),
        .VSYNC_ROWS     (VSR),
        .STRIPE_W       (SW),
        .BAND_H         (BH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .color_a     (color_a),
        .color_b     (color_b),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    // Land on the next clk negedge with pclk low: one sample per pclk period.
    task automatic next_pclk();
        @(negedge clk);
        if (CAM_pclk) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_vsync(output int lat);
        lat = 0;
        while (!CAM_vsync && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_href_rises(input int n, output bit ok);
        int   cnt = 0;
        int   t   = 0;
        logic prev;
        prev = CAM_href;
        ok   = 1'b0;
        while (t < 20000) begin
            next_pclk();
            t++;
            if (CAM_href && !prev) cnt++;
            prev = CAM_href;
            if (cnt == n) begin
                ok = 1'b1;
                t  = 20000;
            end
        end
    endtask

    task automatic test_reset();
        int bad_toggle = 0;
        int noisy      = 0;
        int pclk_hi    = 0;
        logic prev;
        rst = 1'b0; en = 1'b0; mode = 2'd0; color_a = 12'h000; color_b = 12'h000;
        repeat (4) begin
            @(negedge clk);
            if (CAM_pclk) pclk_hi++;
        end
        checks++;
        if ({CAM_pclk, CAM_vsync, CAM_href, frame_done} !== 4'b0 || CAM_px_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got pclk=%b vsync=%b href=%b px=%h done=%b, expected all 0",
                     CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done);
        end
        checks++;
        if (frame_cnt !== 8'd0 || pclk_hi != 0) begin
            errors++;
            $display("FAIL reset_cnt_pclk: got frame_cnt=%0d pclk_high_samples=%0d, expected 0 and 0",
                     frame_cnt, pclk_hi);
        end
        @(negedge clk);
        rst  = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (CAM_pclk === prev) bad_toggle++;
            prev = CAM_pclk;
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || CAM_px_data !== 8'h00 || frame_done !== 1'b0)
                noisy++;
        end
        checks++;
        if (bad_toggle != 0) begin
            errors++;
            $display("FAIL pclk_toggle: got %0d non-toggling clk, expected 0", bad_toggle);
        end
        checks++;
        if (noisy != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active samples with en=0, expected 0", noisy);
        end
    endtask

    task automatic test_stripe_line();
        int lat;
        bit ok;
        int byte_bad = 0;
        int href_bad = 0;
        int first_i  = -1;
        logic [7:0] first_got = 8'h00;
        int hb_bad   = 0;
        apply_reset();
        mode = 2'd1; color_a = 12'h00F; color_b = 12'h0F0; en = 1'b1;
        wait_vsync(lat);
        checks++;
        if (!CAM_vsync || lat < 1 || lat > 2) begin
            errors++;
            $display("FAIL en_to_vsync: got %0d clk (vsync=%b), expected 1..2", lat, CAM_vsync);
        end
        wait_href_rises(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stripe_href_seen: got no href rise, expected one");
        end
        for (int b = 0; b < 2 * TL; b++) begin
            if (CAM_href !== 1'b1) href_bad++;
            if (CAM_px_data !== exp_stripe[b % 8]) begin
                if (first_i < 0) begin
                    first_i   = b;
                    first_got = CAM_px_data;
                end
                byte_bad++;
            end
            next_pclk();
        end
        checks++;
        if (byte_bad != 0) begin
            errors++;
            $display("FAIL stripe_bytes: %0d bad, first byte %0d got %h expected %h",
                     byte_bad, first_i, first_got, exp_stripe[(first_i < 0 ? 0 : first_i) % 8]);
        end
        checks++;
        if (href_bad != 0) begin
            errors++;
            $display("FAIL stripe_href_width: got %0d low periods inside 320, expected 0", href_bad);
        end
        for (int i = 0; i < BTL; i++) begin
            if (CAM_href !== 1'b0 || CAM_px_data !== 8'h00) hb_bad++;
            next_pclk();
        end
        checks++;
        if (hb_bad != 0) begin
            errors++;
            $display("FAIL hblank_quiet: got %0d periods with href/px set, expected 0", hb_bad);
        end
        checks++;
        if (CAM_href !== 1'b1 || CAM_px_data !== 8'h00) begin
            errors++;
            $display("FAIL next_line_start: got href=%b px=%h, expected 1 00", CAM_href, CAM_px_data);
        end
        en = 1'b0;
    endtask

    task automatic test_frame_timing();
        int lat;
        int t = 0, vs_hi = 0, vs_rises = 0, first_href = -1, href_rises = 0, fd = 0, fd_t = -1;
        logic prev_href = 1'b0;
        logic prev_vs   = 1'b1;
        apply_reset();
        mode = 2'd0; color_a = 12'h123; color_b = 12'h456; en = 1'b1;
        wait_vsync(lat);
        en = 1'b0;
        checks++;
        if (CAM_vsync !== 1'b1) begin
            errors++;
            $display("FAIL frame_vsync_start: got vsync=%b after %0d clk, expected 1", CAM_vsync, lat);
        end
        while (t < FRAME_T + 400) begin
            if (CAM_vsync) vs_hi++;
            if (CAM_vsync && !prev_vs) vs_rises++;
            if (CAM_href && !prev_href) begin
                href_rises++;
                if (first_href < 0) first_href = t;
            end
            if (frame_done) begin
                fd++;
                fd_t = t;
            end
            prev_href = CAM_href;
            prev_vs   = CAM_vsync;
            next_pclk();
            t++;
        end
        checks++;
        if (vs_hi != 648) begin
            errors++;
            $display("FAIL vsync_width: got %0d pclk, expected 648", vs_hi);
        end
        checks++;
        if (first_href != 1296) begin
            errors++;
            $display("FAIL first_href_delay: got %0d pclk, expected 1296", first_href);
        end
        checks++;
        if (href_rises != TR) begin
            errors++;
            $display("FAIL href_count: got %0d, expected %0d", href_rises, TR);
        end
        checks++;
        if (fd != 1 || fd_t != FRAME_T) begin
            errors++;
            $display("FAIL frame_done_pulse: got %0d pulses at pclk %0d, expected 1 at %0d", fd, fd_t, FRAME_T);
        end
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_cnt_one: got %0d, expected 1", frame_cnt);
        end
        checks++;
        if (vs_rises != 0 || CAM_vsync !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_frame: got %0d vsync restarts vsync=%b, expected 0 and 0", vs_rises, CAM_vsync);
        end
    endtask

    task automatic test_band_check();
        bit ok;
        int bad;
        apply_reset();
        mode = 2'd2; color_a = 12'hF0F; color_b = 12'h0F0; en = 1'b1;
        wait_href_rises(3, ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            if (CAM_px_data !== 8'h0F) bad++;
            next_pclk();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL band_row2: got %0d bad bytes (last %h), expected 0 (0F,0F)", bad, CAM_px_data);
        end
        wait_href_rises(1, ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            if (CAM_px_data !== ((i % 2 == 0) ? 8'h00 : 8'hF0)) bad++;
            next_pclk();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL band_row3: got %0d bad bytes, expected 0 (00,F0)", bad);
        end
        apply_reset();
        mode = 2'd3; en = 1'b1;
        wait_href_rises(1, ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            if (CAM_px_data !== exp_chk0[i]) bad++;
            next_pclk();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL check_row0: got %0d bad bytes, expected 0", bad);
        end
        wait_href_rises(3, ok);
        bad = ok ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            if (CAM_px_data !== exp_chk3[i]) bad++;
            next_pclk();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL check_row3_inverted: got %0d bad bytes, expected 0", bad);
        end
        en = 1'b0;
    endtask

    task automatic test_mid_change();
        bit ok;
        int bad = 0;
        int t   = 0;
        int act = 0;
        apply_reset();
        mode = 2'd1; color_a = 12'h00F; color_b = 12'h0F0; en = 1'b1;
        wait_href_rises(6, ok);
        mode = 2'd0; color_a = 12'hF00; color_b = 12'h000;
        wait_href_rises(1, ok);
        en = 1'b0;
        wait_href_rises(2, ok);
        if (!ok) bad++;
        for (int i = 0; i < 8; i++) begin
            if (CAM_px_data !== exp_stripe[i]) bad++;
            next_pclk();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL old_pattern_kept: got %0d bad bytes on row 8, expected 0", bad);
        end
        while (!frame_done && t < 4000) begin
            next_pclk();
            t++;
        end
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_completes: got done=%b cnt=%0d, expected 1 and 1", frame_done, frame_cnt);
        end
        for (int i = 0; i < 700; i++) begin
            next_pclk();
            if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || CAM_px_data !== 8'h00) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL idle_after_en_drop: got %0d active periods, expected 0", act);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int lat;
        int n = 0;
        apply_reset();
        mode = 2'd0; color_a = 12'h123; color_b = 12'h456; en = 1'b1;
        wait_href_rises(2, ok);
        repeat (5) next_pclk();
        checks++;
        if (!ok || CAM_href !== 1'b1 || CAM_px_data !== 8'h23) begin
            errors++;
            $display("FAIL pre_reset_byte: got href=%b px=%h, expected 1 23", CAM_href, CAM_px_data);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({CAM_pclk, CAM_vsync, CAM_href, frame_done} !== 4'b0 || CAM_px_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got pclk=%b vsync=%b href=%b px=%h, expected all 0",
                     CAM_pclk, CAM_vsync, CAM_href, CAM_px_data);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_vsync(lat);
        checks++;
        if (!CAM_vsync || lat < 1 || lat > 2) begin
            errors++;
            $display("FAIL restart_latency: got %0d clk (vsync=%b), expected 1..2", lat, CAM_vsync);
        end
        while (CAM_vsync && n < 2000) begin
            n++;
            next_pclk();
        end
        checks++;
        if (n != 648 || CAM_href !== 1'b0) begin
            errors++;
            $display("FAIL restart_full_vsync: got %0d pclk href=%b, expected 648 and 0", n, CAM_href);
        end
        en = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stripe_line();
        test_frame_timing();
        test_band_check();
        test_mid_change();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
